// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch / load-store) and unified memory port signals.
// slave = arbiter side, master = the requesters and memory around it.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;

   logic            d_req;
   logic            d_we;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [DW/8-1:0] d_be;
   logic            d_gnt;
   logic            d_rvalid;
   logic [DW-1:0]   d_rdata;

   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_be;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data has priority; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus,
   output logic              busy
);
   localparam int BW = DW / 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [1:0]    state;
   logic          owner;
   logic [3:0]    starve_cnt;

   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [BW-1:0] mem_be_q;

   logic          if_rvalid_q, d_rvalid_q;
   logic [DW-1:0] if_rdata_q, d_rdata_q;

   logic          idle, grant_i, grant_d, capture;

   // Fetch only beats a pending data request once it has lost STARVE_MAX times.
   always_comb begin
      idle    = (state == IDLE);
      grant_d = idle && bus.d_req && !(bus.if_req && (starve_cnt == STARVE_LIM));
      grant_i = idle && bus.if_req && !grant_d;
      capture = ((state == ISSUE) && bus.mem_gnt && bus.mem_rvalid) ||
                ((state == WAIT)  && bus.mem_rvalid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_req_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i || grant_d) begin
                  state     <= ISSUE;
                  mem_req_q <= 1'b1;
               end
            end
            ISSUE: begin
               // rvalid without gnt is not a response to our request
               if (bus.mem_gnt) begin
                  mem_req_q <= 1'b0;
                  state     <= bus.mem_rvalid ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_rvalid) state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= 4'd0;
      end else if (grant_i) begin
         starve_cnt <= 4'd0;
      end else if (grant_d && bus.if_req && (starve_cnt < STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Request attributes are only loaded on a grant, so they stay frozen in ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= OWN_I;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else if (grant_d) begin
         owner       <= OWN_D;
         mem_we_q    <= bus.d_we;
         mem_addr_q  <= bus.d_addr;
         mem_wdata_q <= bus.d_wdata;
         mem_be_q    <= bus.d_be;
      end else if (grant_i) begin
         owner       <= OWN_I;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= bus.if_addr;
         mem_wdata_q <= '0;
         mem_be_q    <= '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         if_rvalid_q <= capture && (owner == OWN_I);
         d_rvalid_q  <= capture && (owner == OWN_D);
         if (capture && (owner == OWN_I)) if_rdata_q <= bus.mem_rdata;
         if (capture && (owner == OWN_D)) d_rdata_q  <= bus.mem_rdata;
      end
   end

   assign bus.if_gnt    = grant_i;
   assign bus.d_gnt     = grant_d;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
   assign busy          = (state != IDLE);
endmodule
